// File: rtl/apb_timer_pkg.sv
// Shared register map and CTRL field layout for the APB down-counter timer.
package apb_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_VALUE  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_PS_LSB = 8;
    localparam int CTRL_PS_MSB = 15;

    // Assemble the CTRL read word; unused bits read as zero.
    function automatic logic [31:0] pack_ctrl(input logic en, input logic reload,
                                              input logic irq_en, input logic [7:0] ps);
        logic [31:0] word;
        word                          = 32'd0;
        word[CTRL_EN]                 = en;
        word[CTRL_RELOAD]             = reload;
        word[CTRL_IRQ_EN]             = irq_en;
        word[CTRL_PS_MSB:CTRL_PS_LSB] = ps;
        return word;
    endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// Tick divider: one-cycle tick every div+1 enabled cycles, restartable from zero.
module apb_timer_prescaler (
    input  logic       hclk,
    input  logic       hreset,
    input  logic       en,
    input  logic       restart,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] cnt_r;

    // >= keeps the divider from wrapping through 255 if div shrinks mid-count.
    assign tick = en && (cnt_r >= div);

    // Enabled-cycle counter, frozen while disabled.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            cnt_r <= 8'd0;
        end else if (restart || tick) begin
            cnt_r <= 8'd0;
        end else if (en) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB timer slave: programmable down-counter with expiry flag and level irq.
// Optional 8-bit tick prescaler is built when TIMER_PRESCALER_EN is defined.
module apb_timer_slave #(
    parameter int CNT_W    = 32,
    parameter int PSEL_IDX = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [2:0]  pselx,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        irq
);
    import apb_timer_pkg::*;

    logic             sel_s;
    logic             wr_s;
    logic [1:0]       reg_idx_s;
    logic             wr_ctrl_s;
    logic             wr_load_s;
    logic             wr_status_s;
    logic             tick_s;
    logic             zero_s;
    logic [7:0]       prescale_s;
    logic             en_r;
    logic             reload_r;
    logic             irq_en_r;
    logic             expired_r;
    logic [CNT_W-1:0] load_r;
    logic [CNT_W-1:0] value_r;
    logic [31:0]      load_ext_s;
    logic [31:0]      value_ext_s;
    logic             unused_s;

    assign sel_s       = pselx[PSEL_IDX];
    assign wr_s        = sel_s && penable && pwrite;
    assign reg_idx_s   = paddr[3:2];
    assign wr_ctrl_s   = wr_s && (reg_idx_s == REG_CTRL);
    assign wr_load_s   = wr_s && (reg_idx_s == REG_LOAD);
    assign wr_status_s = wr_s && (reg_idx_s == REG_STATUS);
    assign zero_s      = (value_r == {CNT_W{1'b0}});
    assign irq         = expired_r && irq_en_r;
    assign unused_s    = ^{pselx, paddr, pwdata};

`ifdef TIMER_PRESCALER_EN
    logic       restart_s;
    logic [7:0] prescale_r;

    // Only a 0->1 EN transition restarts the divider; rewriting EN=1 does not.
    assign restart_s  = wr_ctrl_s && pwdata[CTRL_EN] && !en_r;
    assign prescale_s = prescale_r;

    // Prescale divisor field of CTRL.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            prescale_r <= 8'd0;
        end else if (wr_ctrl_s) begin
            prescale_r <= pwdata[CTRL_PS_MSB:CTRL_PS_LSB];
        end else begin
            prescale_r <= prescale_r;
        end
    end

    apb_timer_prescaler u_prescaler (
        .hclk    (hclk),
        .hreset  (hreset),
        .en      (en_r),
        .restart (restart_s),
        .div     (prescale_r),
        .tick    (tick_s)
    );
`else
    assign prescale_s = 8'd0;
    assign tick_s     = en_r;
`endif

    // CTRL flags; a software write takes precedence over one-shot self-clear of EN.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            en_r     <= 1'b0;
            reload_r <= 1'b0;
            irq_en_r <= 1'b0;
        end else if (wr_ctrl_s) begin
            en_r     <= pwdata[CTRL_EN];
            reload_r <= pwdata[CTRL_RELOAD];
            irq_en_r <= pwdata[CTRL_IRQ_EN];
        end else if (tick_s && zero_s && !reload_r) begin
            en_r     <= 1'b0;
            reload_r <= reload_r;
            irq_en_r <= irq_en_r;
        end else begin
            en_r     <= en_r;
            reload_r <= reload_r;
            irq_en_r <= irq_en_r;
        end
    end

    // LOAD and the down-counter; a LOAD write overrides a same-edge tick.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            load_r  <= {CNT_W{1'b0}};
            value_r <= {CNT_W{1'b0}};
        end else if (wr_load_s) begin
            load_r  <= pwdata[CNT_W-1:0];
            value_r <= pwdata[CNT_W-1:0];
        end else if (tick_s) begin
            load_r <= load_r;
            if (!zero_s) begin
                value_r <= value_r - CNT_W'(1);
            end else if (reload_r) begin
                value_r <= load_r;
            end else begin
                value_r <= {CNT_W{1'b0}};
            end
        end else begin
            load_r  <= load_r;
            value_r <= value_r;
        end
    end

    // EXPIRED sticky flag; a same-edge expiry beats the write-1-to-clear.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            expired_r <= 1'b0;
        end else if (tick_s && zero_s) begin
            expired_r <= 1'b1;
        end else if (wr_status_s && pwdata[0]) begin
            expired_r <= 1'b0;
        end else begin
            expired_r <= expired_r;
        end
    end

    // Zero-extend the CNT_W-wide registers onto the 32-bit read bus.
    always_comb begin
        load_ext_s               = 32'd0;
        value_ext_s              = 32'd0;
        load_ext_s[CNT_W-1:0]    = load_r;
        value_ext_s[CNT_W-1:0]   = value_r;
    end

    // Read mux, live in both setup and access phases of a selected read.
    always_comb begin
        prdata = 32'd0;
        if (sel_s && !pwrite) begin
            case (reg_idx_s)
                REG_CTRL:   prdata = pack_ctrl(en_r, reload_r, irq_en_r, prescale_s);
                REG_LOAD:   prdata = load_ext_s;
                REG_VALUE:  prdata = value_ext_s;
                REG_STATUS: prdata = {31'd0, expired_r};
                default:    prdata = 32'd0;
            endcase
        end else begin
            prdata = 32'd0;
        end
    end

endmodule
